// File: rtl/clas_nbit_pipe_if.sv
// Operand/result bus of the pipelined CLA adder/subtractor.
// The input side (in_valid/in_ready) carries one operand beat per transfer,
// the output side (out_valid/out_ready) one result beat with its flags.
interface clas_nbit_pipe_if #(
   parameter int WIDTH = 16
);
   logic             in_valid;
   logic             in_ready;
   logic             sel;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] result;
   logic             c_out;
   logic             ovf;
   logic             zero;
   logic             neg;

   // Producer of operands and consumer of results.
   modport master (
      output in_valid, sel, a, b, out_ready,
      input  in_ready, out_valid, result, c_out, ovf, zero, neg
   );

   // The adder/subtractor itself.
   modport slave (
      input  in_valid, sel, a, b, out_ready,
      output in_ready, out_valid, result, c_out, ovf, zero, neg
   );
endinterface

// File: rtl/clas_nbit_pipe.sv
// Two-stage pipelined carry-look-ahead adder/subtractor.
// sel = 0 computes a + b, sel = 1 computes a + ~b + 1. Carries are resolved
// inside BLOCK-bit look-ahead groups and rippled group to group. Stage 1 adds
// the low ceil(NG/2) groups, stage 2 the remaining high groups using the
// registered boundary carry. A valid/ready handshake with backpressure holds
// up to two beats in flight.
module clas_nbit_pipe #(
   parameter int WIDTH = 16,
   parameter int BLOCK = 4
) (
   input  logic            clk,
   input  logic            rst,
   clas_nbit_pipe_if.slave bus
);

   localparam int NG    = WIDTH / BLOCK;
   localparam int NG_LO = (NG + 1) / 2;
   localparam int NG_HI = NG - NG_LO;
   localparam int LO    = NG_LO * BLOCK;
   localparam int HI    = WIDTH - LO;

   generate
      if (((WIDTH % BLOCK) != 0) || (NG < 2)) begin : g_bad_params
         $error("clas_nbit_pipe: WIDTH must be a multiple of BLOCK and WIDTH/BLOCK must be >= 2");
      end
   endgenerate

   // One look-ahead group. Each internal carry is a flat OR of products of
   // the g/p terms and the group carry-in, so nothing ripples inside a group.
   // Returns {group carry out, BLOCK sum bits}.
   function automatic logic [BLOCK:0] cla_group(
      input logic [BLOCK-1:0] x,
      input logic [BLOCK-1:0] y,
      input logic             cin
   );
      logic [BLOCK-1:0] g;
      logic [BLOCK-1:0] p;
      logic [BLOCK-1:0] s;
      logic [BLOCK:0]   c;
      logic             term;
      g = x & y;
      p = x | y;
      c = '0;
      for (int i = 0; i <= BLOCK; i++) begin
         // carry-in propagated through p[0..i-1]
         term = cin;
         for (int k = 0; k < i; k++) begin
            term = term & p[k];
         end
         c[i] = term;
         // generate at bit j propagated through p[j+1..i-1]
         for (int j = 0; j < i; j++) begin
            term = g[j];
            for (int k = j + 1; k < i; k++) begin
               term = term & p[k];
            end
            c[i] = c[i] | term;
         end
      end
      s = x ^ y ^ c[BLOCK-1:0];
      return {c[BLOCK], s};
   endfunction

   // Handshake state
   logic          r_s1_valid;
   logic          r_s2_valid;
   logic          w_in_ready;
   logic          w_in_xfer;
   logic          w_adv2;
   logic          w_out_xfer;

   // Stage-1 datapath
   logic [WIDTH-1:0] w_b_eff;
   logic [LO-1:0]    w_sum_lo;
   logic             w_carry_lo;
   logic [LO-1:0]    r_s1_sum_lo;
   logic             r_s1_carry;
   logic [HI-1:0]    r_s1_a_hi;
   logic [HI-1:0]    r_s1_b_hi;

   // Stage-2 datapath
   logic [HI-1:0]    w_sum_hi;
   logic             w_carry_hi;
   logic [WIDTH-1:0] w_result;
   logic             w_ovf;
   logic [WIDTH-1:0] r_result;
   logic             r_c_out;
   logic             r_ovf;
   logic             r_zero;
   logic             r_neg;

   // Stage 2 advances when it is empty or its result leaves this cycle;
   // in_ready depends only on pipeline state, out_ready and rst.
   assign w_adv2     = r_s1_valid && (!r_s2_valid || bus.out_ready);
   assign w_in_ready = !rst && (!r_s1_valid || w_adv2);
   assign w_in_xfer  = bus.in_valid && w_in_ready;
   assign w_out_xfer = r_s2_valid && bus.out_ready;

   // Subtraction inverts B; the +1 enters as the low carry-in.
   assign w_b_eff = bus.b ^ {WIDTH{bus.sel}};

   // Stage-1 groups: low half of the word, carry-in = sel.
   always_comb begin
      logic [BLOCK:0] grp;
      logic           c;
      // NOTE: defaults first so every path assigns every output; no latch.
      w_sum_lo = '0;
      grp      = '0;
      c        = bus.sel;
      for (int gi = 0; gi < NG_LO; gi++) begin
         grp = cla_group(bus.a[gi*BLOCK +: BLOCK], w_b_eff[gi*BLOCK +: BLOCK], c);
         w_sum_lo[gi*BLOCK +: BLOCK] = grp[BLOCK-1:0];
         c = grp[BLOCK];
      end
      w_carry_lo = c;
   end

   // Stage-2 groups: high half of the word, fed by the registered carry.
   always_comb begin
      logic [BLOCK:0] grp;
      logic           c;
      w_sum_hi = '0;
      grp      = '0;
      c        = r_s1_carry;
      for (int gi = 0; gi < NG_HI; gi++) begin
         grp = cla_group(r_s1_a_hi[gi*BLOCK +: BLOCK], r_s1_b_hi[gi*BLOCK +: BLOCK], c);
         w_sum_hi[gi*BLOCK +: BLOCK] = grp[BLOCK-1:0];
         c = grp[BLOCK];
      end
      w_carry_hi = c;
   end

   // Carry into the MSB is recovered from the MSB sum bit: a ^ b ^ s.
   assign w_result = {w_sum_hi, r_s1_sum_lo};
   assign w_ovf    = (r_s1_a_hi[HI-1] ^ r_s1_b_hi[HI-1] ^ w_sum_hi[HI-1]) ^ w_carry_hi;

   // Stage-1 register: low sum, boundary carry and the untouched high operands.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s1_valid  <= 1'b0;
         r_s1_sum_lo <= '0;
         r_s1_carry  <= 1'b0;
         r_s1_a_hi   <= '0;
         r_s1_b_hi   <= '0;
      end else begin
         // NOTE: non-blocking so every register samples pre-edge values.
         if (w_in_xfer) begin
            r_s1_sum_lo <= w_sum_lo;
            r_s1_carry  <= w_carry_lo;
            r_s1_a_hi   <= bus.a[WIDTH-1:LO];
            r_s1_b_hi   <= w_b_eff[WIDTH-1:LO];
         end
         if (w_in_xfer) begin
            r_s1_valid <= 1'b1;
         end else if (w_adv2) begin
            r_s1_valid <= 1'b0;
         end
      end
   end

   // Stage-2 register: full result and flags, held while the consumer stalls.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s2_valid <= 1'b0;
         r_result   <= '0;
         r_c_out    <= 1'b0;
         r_ovf      <= 1'b0;
         r_zero     <= 1'b0;
         r_neg      <= 1'b0;
      end else begin
         if (w_adv2) begin
            r_result <= w_result;
            r_c_out  <= w_carry_hi;
            r_ovf    <= w_ovf;
            r_zero   <= (w_result == '0);
            r_neg    <= w_result[WIDTH-1];
         end
         if (w_adv2) begin
            r_s2_valid <= 1'b1;
         end else if (w_out_xfer) begin
            r_s2_valid <= 1'b0;
         end
      end
   end

   assign bus.in_ready  = w_in_ready;
   assign bus.out_valid = r_s2_valid;
   assign bus.result    = r_result;
   assign bus.c_out     = r_c_out;
   assign bus.ovf       = r_ovf;
   assign bus.zero      = r_zero;
   assign bus.neg       = r_neg;

endmodule

// File: tb/tb_clas_nbit_pipe.sv
// Bench for clas_nbit_pipe. Three instances (16/4, 32/4, 12/4) share one
// stimulus stream and run in lockstep; every result is compared against an
// arithmetic reference model for its own width, held in an in-order queue.
module tb_clas_nbit_pipe;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        sel;
   logic        out_ready;
   logic [31:0] a;
   logic [31:0] b;

   int total = 0;
   int bad   = 0;
   int n_out = 0;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic        sel;
   } beat_t;

   beat_t q[$];

   always #5 clk = ~clk;

   clas_nbit_pipe_if #(.WIDTH(16)) bus16 ();
   clas_nbit_pipe_if #(.WIDTH(32)) bus32 ();
   clas_nbit_pipe_if #(.WIDTH(12)) bus12 ();

   assign bus16.in_valid  = in_valid;
   assign bus16.sel       = sel;
   assign bus16.a         = a[15:0];
   assign bus16.b         = b[15:0];
   assign bus16.out_ready = out_ready;

   assign bus32.in_valid  = in_valid;
   assign bus32.sel       = sel;
   assign bus32.a         = a;
   assign bus32.b         = b;
   assign bus32.out_ready = out_ready;

   assign bus12.in_valid  = in_valid;
   assign bus12.sel       = sel;
   assign bus12.a         = a[11:0];
   assign bus12.b         = b[11:0];
   assign bus12.out_ready = out_ready;

   clas_nbit_pipe #(.WIDTH(16), .BLOCK(4)) dut16 (.clk(clk), .rst(rst), .bus(bus16));
   clas_nbit_pipe #(.WIDTH(32), .BLOCK(4)) dut32 (.clk(clk), .rst(rst), .bus(bus32));
   clas_nbit_pipe #(.WIDTH(12), .BLOCK(4)) dut12 (.clk(clk), .rst(rst), .bus(bus12));

   // Reference: plain modular arithmetic. Returns {c_out, ovf, zero, neg, result}.
   function automatic logic [35:0] model(input int w, input logic [31:0] xa,
                                         input logic [31:0] xb, input logic xsel);
      longint unsigned mask, ua, ub, res;
      logic co, ov, sa, sb, sr;
      mask = (64'd1 << w) - 64'd1;
      ua   = {32'd0, xa} & mask;
      ub   = {32'd0, xb} & mask;
      if (xsel) begin
         res = (ua - ub) & mask;
         co  = (ua >= ub);              // no borrow
      end else begin
         res = (ua + ub) & mask;
         co  = (((ua + ub) >> w) != 0);
      end
      sa = ua[w-1];
      sb = ub[w-1];
      sr = res[w-1];
      // Signed overflow: add of like signs, or sub of unlike signs, flipping sign of a.
      ov = xsel ? ((sa != sb) && (sr != sa)) : ((sa == sb) && (sr != sa));
      return {co, ov, (res == 0), sr, res[31:0]};
   endfunction

   function automatic logic [31:0] rnd_op();
      logic [31:0] specials [8];
      specials = '{32'h0, 32'hFFFF_FFFF, 32'h7FF, 32'h800, 32'h7FFF, 32'h8000,
                   32'h7FFF_FFFF, 32'h8000_0000};
      if ($urandom_range(0, 3) == 0) return specials[$urandom_range(0, 7)];
      return $urandom;
   endfunction

   // One cycle, entered at a falling edge with inputs already driven.
   // Compares the result at the queue head whenever out_valid is high, so a
   // stalled result is re-checked every cycle it is held.
   task automatic step(output bit acc);
      logic [35:0] e16, e32, e12, o16, o32, o12;
      #1;
      total++;
      if (bus32.in_ready !== bus16.in_ready || bus12.in_ready !== bus16.in_ready ||
          bus32.out_valid !== bus16.out_valid || bus12.out_valid !== bus16.out_valid) begin
         bad++;
         $display("FAIL lockstep: in_ready(16/32/12)=%b/%b/%b out_valid=%b/%b/%b, want all equal",
                  bus16.in_ready, bus32.in_ready, bus12.in_ready,
                  bus16.out_valid, bus32.out_valid, bus12.out_valid);
      end
      if (bus16.out_valid === 1'b1) begin
         if (q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL spurious_out: out_valid=1 result=%h, want no beat (none in flight)", bus16.result);
         end else begin
            e16 = model(16, q[0].a, q[0].b, q[0].sel);
            e32 = model(32, q[0].a, q[0].b, q[0].sel);
            e12 = model(12, q[0].a, q[0].b, q[0].sel);
            o16 = {bus16.c_out, bus16.ovf, bus16.zero, bus16.neg, 16'd0, bus16.result};
            o32 = {bus32.c_out, bus32.ovf, bus32.zero, bus32.neg, bus32.result};
            o12 = {bus12.c_out, bus12.ovf, bus12.zero, bus12.neg, 20'd0, bus12.result};
            total++;
            if (o16 !== e16) begin
               bad++;
               $display("FAIL w16_beat a=%h b=%h sel=%b: got cozn=%b res=%h, want cozn=%b res=%h",
                        q[0].a[15:0], q[0].b[15:0], q[0].sel, o16[35:32], o16[31:0], e16[35:32], e16[31:0]);
            end
            total++;
            if (o32 !== e32) begin
               bad++;
               $display("FAIL w32_beat a=%h b=%h sel=%b: got cozn=%b res=%h, want cozn=%b res=%h",
                        q[0].a, q[0].b, q[0].sel, o32[35:32], o32[31:0], e32[35:32], e32[31:0]);
            end
            total++;
            if (o12 !== e12) begin
               bad++;
               $display("FAIL w12_beat a=%h b=%h sel=%b: got cozn=%b res=%h, want cozn=%b res=%h",
                        q[0].a[11:0], q[0].b[11:0], q[0].sel, o12[35:32], o12[31:0], e12[35:32], e12[31:0]);
            end
            if (out_ready) begin
               void'(q.pop_front());
               n_out++;
            end
         end
      end
      acc = in_valid && (bus16.in_ready === 1'b1);
      if (acc) q.push_back('{a: a, b: b, sel: sel});
      @(posedge clk);
      @(negedge clk);
   endtask

   // Empty the pipeline with a bounded cycle budget.
   task automatic drain();
      bit acc;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 10 && q.size() != 0; i++) step(acc);
      total++;
      if (q.size() != 0) begin
         bad++;
         $display("FAIL drain_timeout: %0d beats left, want 0", q.size());
      end
   endtask

   task automatic test_reset();
      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      sel       = 1'b0;
      a         = '0;
      b         = '0;
      @(negedge clk);
      @(negedge clk);
      #1;
      total++;
      if (bus16.out_valid !== 1'b0 || bus16.result !== 16'h0 || bus16.c_out !== 1'b0 ||
          bus16.ovf !== 1'b0 || bus16.zero !== 1'b0 || bus16.neg !== 1'b0 || bus16.in_ready !== 1'b0) begin
         bad++;
         $display("FAIL reset_state: v=%b res=%h c=%b o=%b z=%b n=%b rdy=%b, want all 0",
                  bus16.out_valid, bus16.result, bus16.c_out, bus16.ovf, bus16.zero, bus16.neg, bus16.in_ready);
      end
      @(negedge clk);
      rst = 1'b0;
      #1;
      total++;
      if (bus16.in_ready !== 1'b1 || bus32.in_ready !== 1'b1 || bus12.in_ready !== 1'b1) begin
         bad++;
         $display("FAIL ready_after_reset: in_ready(16/32/12)=%b/%b/%b, want 1",
                  bus16.in_ready, bus32.in_ready, bus12.in_ready);
      end
      @(negedge clk);
   endtask

   typedef struct packed {
      logic [15:0] a;
      logic [15:0] b;
      logic        sel;
      logic [15:0] res;
      logic        co;
      logic        ov;
      logic        z;
      logic        n;
   } dvec_t;

   task automatic test_directed();
      dvec_t vecs [8];
      bit    acc;
      vecs = '{
         '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b1},
         '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0},
         '{16'h0005, 16'h0005, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0},
         '{16'h0003, 16'h0005, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0, 1'b1},
         '{16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0, 1'b0},
         '{16'h1234, 16'h0000, 1'b1, 16'h1234, 1'b1, 1'b0, 1'b0, 1'b0},
         '{16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0, 1'b0},
         '{16'h07FF, 16'h0001, 1'b0, 16'h0800, 1'b0, 1'b0, 1'b0, 1'b0}
      };
      out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         a        = {16'd0, vecs[i].a};
         b        = {16'd0, vecs[i].b};
         sel      = vecs[i].sel;
         in_valid = 1'b1;
         step(acc);                       // accepted at edge N
         total++;
         if (!acc) begin
            bad++;
            $display("FAIL dir_accept[%0d]: in_ready=0, want beat accepted", i);
         end
         in_valid = 1'b0;
         #1;
         total++;
         if (bus16.out_valid !== 1'b0) begin
            bad++;
            $display("FAIL dir_latency_early[%0d]: out_valid=%b after edge N, want 0", i, bus16.out_valid);
         end
         step(acc);                       // edge N+1
         #1;
         total++;
         if (bus16.out_valid !== 1'b1 || bus16.result !== vecs[i].res || bus16.c_out !== vecs[i].co ||
             bus16.ovf !== vecs[i].ov || bus16.zero !== vecs[i].z || bus16.neg !== vecs[i].n) begin
            bad++;
            $display("FAIL dir[%0d]: got v=%b res=%h c=%b o=%b z=%b n=%b, want v=1 res=%h c=%b o=%b z=%b n=%b",
                     i, bus16.out_valid, bus16.result, bus16.c_out, bus16.ovf, bus16.zero, bus16.neg,
                     vecs[i].res, vecs[i].co, vecs[i].ov, vecs[i].z, vecs[i].n);
         end
         step(acc);                       // result consumed
      end
      drain();
   endtask

   task automatic test_backpressure();
      logic [31:0] ba [4];
      logic [31:0] bb [4];
      logic        bs [4];
      int          idx;
      int          n0;
      bit          acc;
      for (int i = 0; i < 4; i++) begin
         ba[i] = rnd_op();
         bb[i] = rnd_op();
         bs[i] = 1'($urandom_range(0, 1));
      end
      n0        = n_out;
      idx       = 0;
      out_ready = 1'b0;
      for (int c = 0; c < 6; c++) begin
         in_valid = (idx < 4);
         a        = ba[idx % 4];
         b        = bb[idx % 4];
         sel      = bs[idx % 4];
         step(acc);
         if (acc) idx++;
      end
      #1;
      total++;
      if (idx != 2 || bus16.in_ready !== 1'b0) begin
         bad++;
         $display("FAIL bp_capacity: accepted=%0d in_ready=%b, want accepted=2 in_ready=0", idx, bus16.in_ready);
      end
      out_ready = 1'b1;
      for (int c = 0; c < 20 && idx < 4; c++) begin
         in_valid = 1'b1;
         a        = ba[idx];
         b        = bb[idx];
         sel      = bs[idx];
         step(acc);
         if (acc) idx++;
      end
      total++;
      if (idx != 4) begin
         bad++;
         $display("FAIL bp_resume: accepted=%0d, want 4", idx);
      end
      drain();
      total++;
      if (n_out - n0 != 4) begin
         bad++;
         $display("FAIL bp_count: results=%0d, want 4", n_out - n0);
      end
   endtask

   task automatic test_stream();
      int n0;
      int n_acc;
      bit acc;
      n0        = n_out;
      n_acc     = 0;
      out_ready = 1'b1;
      for (int i = 0; i < 100; i++) begin
         in_valid = 1'b1;
         a        = rnd_op();
         b        = rnd_op();
         sel      = 1'($urandom_range(0, 1));
         step(acc);
         if (acc) n_acc++;
      end
      total++;
      if (n_acc != 100 || n_out - n0 != 98) begin
         bad++;
         $display("FAIL stream_rate: accepted=%0d results=%0d, want 100 and 98", n_acc, n_out - n0);
      end
      drain();
      total++;
      if (n_out - n0 != 100) begin
         bad++;
         $display("FAIL stream_count: results=%0d, want 100", n_out - n0);
      end
   endtask

   task automatic test_random_flow();
      int n0;
      int n_acc;
      bit acc;
      n0    = n_out;
      n_acc = 0;
      for (int i = 0; i < 300; i++) begin
         in_valid  = ($urandom_range(0, 9) < 7);
         out_ready = ($urandom_range(0, 9) < 6);
         a         = rnd_op();
         b         = rnd_op();
         sel       = 1'($urandom_range(0, 1));
         step(acc);
         if (acc) n_acc++;
      end
      drain();
      total++;
      if (n_out - n0 != n_acc) begin
         bad++;
         $display("FAIL random_count: results=%0d, want %0d", n_out - n0, n_acc);
      end
   endtask

   task automatic test_reset_midstream();
      int n_acc;
      int n0;
      bit acc;
      n_acc     = 0;
      out_ready = 1'b0;
      for (int c = 0; c < 4 && n_acc < 2; c++) begin
         in_valid = 1'b1;
         a        = rnd_op();
         b        = rnd_op();
         sel      = 1'($urandom_range(0, 1));
         step(acc);
         if (acc) n_acc++;
      end
      in_valid = 1'b0;
      #1;
      total++;
      if (n_acc != 2 || bus16.out_valid !== 1'b1) begin
         bad++;
         $display("FAIL rst_setup: accepted=%0d out_valid=%b, want 2 and 1", n_acc, bus16.out_valid);
      end
      #2;
      rst = 1'b1;                         // between clock edges
      #1;
      total++;
      if (bus16.out_valid !== 1'b0 || bus16.result !== 16'h0 || bus16.c_out !== 1'b0 ||
          bus16.ovf !== 1'b0 || bus16.zero !== 1'b0 || bus16.neg !== 1'b0 || bus16.in_ready !== 1'b0) begin
         bad++;
         $display("FAIL rst_async_w16: v=%b res=%h c=%b o=%b z=%b n=%b rdy=%b, want all 0",
                  bus16.out_valid, bus16.result, bus16.c_out, bus16.ovf, bus16.zero, bus16.neg, bus16.in_ready);
      end
      total++;
      if (bus32.out_valid !== 1'b0 || bus32.result !== 32'h0 || bus12.out_valid !== 1'b0 ||
          bus12.result !== 12'h0 || {bus32.c_out, bus32.ovf, bus32.zero, bus32.neg} !== 4'b0 ||
          {bus12.c_out, bus12.ovf, bus12.zero, bus12.neg} !== 4'b0) begin
         bad++;
         $display("FAIL rst_async_w32_w12: v=%b/%b res=%h/%h, want v=0 and all outputs 0",
                  bus32.out_valid, bus12.out_valid, bus32.result, bus12.result);
      end
      q.delete();
      out_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      total++;
      if (bus16.in_ready !== 1'b1 || bus16.out_valid !== 1'b0) begin
         bad++;
         $display("FAIL rst_release: in_ready=%b out_valid=%b, want 1 and 0", bus16.in_ready, bus16.out_valid);
      end
      n0       = n_out;
      a        = rnd_op();
      b        = rnd_op();
      sel      = 1'($urandom_range(0, 1));
      in_valid = 1'b1;
      step(acc);
      total++;
      if (!acc) begin
         bad++;
         $display("FAIL rst_first_accept: in_ready=0, want beat accepted");
      end
      for (int c = 0; c < 4; c++) begin
         in_valid = 1'b0;
         step(acc);
      end
      drain();
      total++;
      if (n_out - n0 != 1) begin
         bad++;
         $display("FAIL rst_no_stale: results=%0d, want 1", n_out - n0);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_directed();
      test_backpressure();
      test_stream();
      test_random_flow();
      test_reset_midstream();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
